// File: rtl/register_bank_reader.sv
// Reader for the MLP result registers: on start, snapshots NUM_WORDS parallel
// words and streams them one per transfer over a valid/ready handshake.
// Words pass through bit-exact. A done pulse follows the final transfer.
module register_bank_reader #(
  parameter int WIDTH     = 21,
  parameter int NUM_WORDS = 10,
  parameter int IDX_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NUM_WORDS*WIDTH-1:0] in_bus,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [IDX_W-1:0]           out_index,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                              state_reg, state_next;
  logic [IDX_W-1:0]                    index_reg, index_next;
  logic [WIDTH-1:0]                    data_reg, data_next;
  logic                                valid_reg, valid_next;
  logic                                last_reg, last_next;
  logic                                busy_reg, busy_next;
  logic                                done_reg, done_next;
  logic                                capture;

  // Packed so that word k sits at the same bit offset as in in_bus.
  logic [NUM_WORDS-1:0][WIDTH-1:0]     snap_reg;

  logic [IDX_W-1:0]                    idx_inc;
  logic [WIDTH-1:0]                    next_word;

  // Snapshot of the parallel result words, taken only when a start is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_reg <= '0;
    end else if (capture) begin
      snap_reg <= in_bus;
    end
  end

  // Select the word following the current index without indexing past the array.
  always_comb begin
    idx_inc   = index_reg + IDX_W'(1);
    next_word = snap_reg[0];
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (idx_inc == IDX_W'(k)) begin
        next_word = snap_reg[k];
      end
    end
  end

  // Next-state and registered-output logic; everything holds unless changed below.
  always_comb begin
    state_next = state_reg;
    index_next = index_reg;
    data_next  = data_reg;
    valid_next = valid_reg;
    last_next  = last_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    capture    = 1'b0;

    case (state_reg)
      IDLE: begin
        valid_next = 1'b0;
        busy_next  = 1'b0;
        last_next  = 1'b0;
        if (start) begin
          // Word 0 comes straight from the bus so it is valid one cycle later.
          capture    = 1'b1;
          state_next = STREAM;
          index_next = '0;
          data_next  = in_bus[WIDTH-1:0];
          valid_next = 1'b1;
          busy_next  = 1'b1;
          last_next  = 1'b0;
        end
      end
      STREAM: begin
        // start is ignored here, including during the final transfer.
        if (valid_reg && out_ready) begin
          if (index_reg == LAST_IDX) begin
            // Index stays saturated; data keeps the last word.
            state_next = IDLE;
            valid_next = 1'b0;
            busy_next  = 1'b0;
            last_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            index_next = idx_inc;
            data_next  = next_word;
            last_next  = (idx_inc == LAST_IDX);
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any stream immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      index_reg <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      index_reg <= index_next;
      data_reg  <= data_next;
      valid_reg <= valid_next;
      last_reg  <= last_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign out_last  = last_reg;
  assign out_index = index_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule

// File: tb/tb_register_bank_reader.sv
// Bench for register_bank_reader: table-driven streams, hand-written reset and
// restart sequences, then random traffic against a queue-free behavioural model.
module tb_register_bank_reader;

  localparam int W  = 21;
  localparam int NW = 10;
  localparam int IW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [NW*W-1:0] in_bus;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [IW-1:0]   out_index;
  logic            busy;
  logic            done;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] cur_words  [NW];
  logic [W-1:0] next_words [NW];

  typedef struct {
    logic [W-1:0]  w0;
    logic [W-1:0]  step;
    int            period;
    int            phase;
    int            scramble_beat;
    logic [NW-1:0] start_mask;
    int            exp_final;
  } vec_t;

  vec_t tbl [6];

  register_bank_reader #(.WIDTH(W), .NUM_WORDS(NW), .IDX_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_bus    (in_bus),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_index (out_index),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_bus(input bit use_next);
    for (int k = 0; k < NW; k++) begin
      in_bus[k*W +: W] = use_next ? next_words[k] : cur_words[k];
    end
  endtask

  // Runs one stream of cur_words and checks every cycle until the idle cycle after done.
  task automatic run_stream(input int id, input int period, input int phase,
                            input int scramble_beat, input logic [NW-1:0] start_mask,
                            input int exp_final, input bit skip_start,
                            input bit restart_in_done);
    int b = 0;
    int c = 0;
    int final_c = -1;
    if (!skip_start) begin
      load_bus(1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    chk($sformatf("s%0d_busy_first", id), 64'(busy), 64'd1);
    while (b < NW && c < 200) begin
      chk($sformatf("s%0d_valid_c%0d", id, c), 64'(out_valid), 64'd1);
      chk($sformatf("s%0d_data_b%0d", id, b), 64'(out_data), 64'(cur_words[b]));
      chk($sformatf("s%0d_index_b%0d", id, b), 64'(out_index), 64'(b));
      chk($sformatf("s%0d_last_b%0d", id, b), 64'(out_last), 64'(b == NW - 1));
      chk($sformatf("s%0d_nodone_c%0d", id, c), 64'(done), 64'd0);
      out_ready = ((c + phase) % period == 0);
      start = start_mask[b];
      if (scramble_beat >= 0 && b == scramble_beat) in_bus = {NW{21'h0AAAAA}};
      if (out_ready) begin
        b++;
        final_c = c;
      end
      tick();
      c++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    chk($sformatf("s%0d_transfers", id), 64'(b), 64'(NW));
    chk($sformatf("s%0d_final_cycle", id), 64'(final_c), 64'(exp_final));
    chk($sformatf("s%0d_done_pulse", id), 64'(done), 64'd1);
    chk($sformatf("s%0d_valid_after", id), 64'(out_valid), 64'd0);
    chk($sformatf("s%0d_busy_after", id), 64'(busy), 64'd0);
    chk($sformatf("s%0d_last_after", id), 64'(out_last), 64'd0);
    if (restart_in_done) begin
      load_bus(1'b1);
      start = 1'b1;
      tick();
      start = 1'b0;
    end else begin
      tick();
      chk($sformatf("s%0d_done_once", id), 64'(done), 64'd0);
      chk($sformatf("s%0d_idle_valid", id), 64'(out_valid), 64'd0);
      chk($sformatf("s%0d_idle_busy", id), 64'(busy), 64'd0);
    end
  endtask

  initial begin
    bit              active;
    int              b;
    bit              done_exp;
    logic [W-1:0]    snap [NW];

    // Row fields: w0, step, ready period, ready phase, scramble beat, start mask, final cycle.
    tbl[0] = '{21'h000001, 21'h000001, 1, 0, -1, '0, 9};
    tbl[1] = '{21'h000001, 21'h000001, 2, 1, -1, '0, 19};
    tbl[2] = '{21'h000001, 21'h000001, 1, 0, 3, '0, 9};
    tbl[3] = '{21'h000001, 21'h000001, 1, 0, -1, 10'b10_0000_0010, 9};
    tbl[4] = '{21'h000123, 21'h00F0F1, 3, 2, -1, '0, 28};
    tbl[5] = '{21'h1FFFF0, 21'h000007, 1, 0, -1, '0, 9};

    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    in_bus = '0;
    #1;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_last", 64'(out_last), 64'd0);
    chk("reset_index", 64'(out_index), 64'd0);
    chk("reset_data", 64'(out_data), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NW; k++) cur_words[k] = tbl[i].w0 + W'(k) * tbl[i].step;
      run_stream(i, tbl[i].period, tbl[i].phase, tbl[i].scramble_beat,
                 tbl[i].start_mask, tbl[i].exp_final, 1'b0, 1'b0);
    end

    // Reset in mid-stream at index 4, then a fresh stream from word 0.
    for (int k = 0; k < NW; k++) cur_words[k] = W'(100 + 5 * k);
    load_bus(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("abort_index_before", 64'(out_index), 64'd4);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_index", 64'(out_index), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    rst = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("abort_nodone_%0d", j), 64'(done), 64'd0);
      chk($sformatf("abort_idle_%0d", j), 64'(out_valid), 64'd0);
    end
    for (int k = 0; k < NW; k++) cur_words[k] = W'(7000 + 3 * k);
    run_stream(6, 1, 0, -1, '0, 9, 1'b0, 1'b0);

    // Extreme words, then a start in the done cycle chaining a second stream.
    for (int k = 0; k < NW; k++) cur_words[k] = W'($urandom());
    cur_words[0]  = 21'h000000;
    cur_words[NW-1] = 21'h1FFFFF;
    for (int k = 0; k < NW; k++) next_words[k] = W'($urandom());
    run_stream(7, 1, 0, -1, '0, 9, 1'b0, 1'b1);
    for (int k = 0; k < NW; k++) cur_words[k] = next_words[k];
    run_stream(8, 1, 0, -1, '0, 9, 1'b1, 1'b0);

    // Random traffic against a behavioural model of the transfer rules.
    active = 1'b0;
    b = 0;
    done_exp = 1'b0;
    for (int k = 0; k < NW; k++) snap[k] = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk($sformatf("rnd_valid_%0d", cyc), 64'(out_valid), 64'(active));
      chk($sformatf("rnd_busy_%0d", cyc), 64'(busy), 64'(active));
      chk($sformatf("rnd_done_%0d", cyc), 64'(done), 64'(done_exp));
      if (active) begin
        chk($sformatf("rnd_data_%0d", cyc), 64'(out_data), 64'(snap[b]));
        chk($sformatf("rnd_index_%0d", cyc), 64'(out_index), 64'(b));
        chk($sformatf("rnd_last_%0d", cyc), 64'(out_last), 64'(b == NW - 1));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < NW; k++) in_bus[k*W +: W] = W'($urandom());
      done_exp = 1'b0;
      if (!active) begin
        if (start) begin
          active = 1'b1;
          b = 0;
          for (int k = 0; k < NW; k++) snap[k] = in_bus[k*W +: W];
        end
      end else if (out_ready) begin
        if (b == NW - 1) begin
          active = 1'b0;
          done_exp = 1'b1;
        end else begin
          b++;
        end
      end
      tick();
    end
    start = 1'b0;
    out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
